pcie_rx_lane_deskew_ctrl: RTL and testbench

Per-link controller that sequences the multi-lane PHY RX datapath after the per-lane deserializers. It measures inter-lane skew from per-lane alignment-marker detections and programs per-lane delay selects in front of byte un-striping. It issues a one-cycle descrambler resync pulse and gates un-striping/packet filtering with rx_ready. In LOCKED it re-measures every marker window and drops lock after repeated mismatches.

---
 rtl/pcie_rx_lane_deskew_ctrl_pkg.sv | 24 ++
 rtl/pcie_rx_lane_deskew_ctrl_if.sv | 31 +++
 rtl/pcie_rx_skew_measure.sv | 90 +++++++++
 rtl/pcie_rx_lane_deskew_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pcie_rx_lane_deskew_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_rx_lane_deskew_ctrl_pkg.sv
// Shared types for the PCIe RX lane deskew controller:
// FSM state encoding and lane offset sizing.
package pcie_phy_rx_pkg;

  function automatic int off_w(input int max_skew);
    return (max_skew < 1) ? 1 : $clog2(max_skew + 1);
  endfunction

  localparam int DEF_MAX_SKEW = 7;
  localparam int DEF_OFF_W    = off_w(DEF_MAX_SKEW);

  typedef logic [DEF_OFF_W-1:0] lane_offset_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_MARKER,
    ST_MEASURE,
    ST_APPLY,
    ST_SETTLE,
    ST_LOCKED,
    ST_ERROR
  } rx_deskew_state_e;

endpackage

// File: rtl/pcie_rx_lane_deskew_ctrl_if.sv
// Lane status in, deskew controls out, between the PHY RX
// lanes (master) and the deskew controller (slave).
interface pcie_rx_lane_deskew_ctrl_if
  import pcie_phy_rx_pkg::*;
#(
  parameter int LANE_COUNT = 4,
  parameter int MAX_SKEW   = 7
);
  localparam int OFF_W = off_w(MAX_SKEW);

  logic                        enable;
  logic [LANE_COUNT-1:0]       lane_valid;
  logic [LANE_COUNT-1:0]       lane_marker;
  logic [LANE_COUNT*OFF_W-1:0] lane_delay_sel;
  logic                        descr_sync;
  logic                        rx_ready;
  logic                        lock_lost;
  logic                        align_error;

  modport master (
    output enable, lane_valid, lane_marker,
    input  lane_delay_sel, descr_sync, rx_ready,
    input  lock_lost, align_error
  );

  modport slave (
    input  enable, lane_valid, lane_marker,
    output lane_delay_sel, descr_sync, rx_ready,
    output lock_lost, align_error
  );
endinterface

// File: rtl/pcie_rx_skew_measure.sv
// One marker window: the first marking lane opens it, each
// lane's first marker records its cycle offset in the window.
module pcie_rx_skew_measure
  import pcie_phy_rx_pkg::*;
#(
  parameter int LANE_COUNT = 4,
  parameter int MAX_SKEW   = 7,
  localparam int OFF_W     = off_w(MAX_SKEW)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_i,
  input  logic                             clear_i,
  input  logic [LANE_COUNT-1:0]            mk_i,
  output logic                             done_o,
  output logic                             timeout_o,
  output logic [LANE_COUNT-1:0][OFF_W-1:0] offsets_o,
  output logic [OFF_W-1:0]                 max_offset_o
);
  localparam logic [OFF_W-1:0] SKEW_LAST = OFF_W'(MAX_SKEW);

  logic                             active_q, active_d;
  logic [OFF_W-1:0]                 wcnt_q, wcnt_d;
  logic [LANE_COUNT-1:0]            seen_q, seen_d;
  logic [LANE_COUNT-1:0]            new_mk;
  logic [LANE_COUNT-1:0][OFF_W-1:0] off_q, off_d;
  logic                             first;

  always_comb begin
    first     = start_i & ~active_q & (|mk_i);
    new_mk    = '0;
    seen_d    = seen_q;
    off_d     = off_q;
    wcnt_d    = wcnt_q;
    active_d  = active_q;
    done_o    = 1'b0;
    timeout_o = 1'b0;
    if (first) begin
      new_mk   = mk_i;
      seen_d   = mk_i;
      off_d    = '0;
      wcnt_d   = OFF_W'(1);
      active_d = 1'b1;
    end else if (active_q) begin
      new_mk = mk_i & ~seen_q;
      seen_d = seen_q | new_mk;
      for (int i = 0; i < LANE_COUNT; i++)
        if (new_mk[i]) off_d[i] = wcnt_q;
      wcnt_d = wcnt_q + 1'b1;
    end
    if (first || active_q) begin
      done_o    = &seen_d;
      timeout_o = active_q & ~done_o & (wcnt_q == SKEW_LAST);
      if (done_o || timeout_o) active_d = 1'b0;
    end
    if (clear_i) begin
      active_d  = 1'b0;
      seen_d    = '0;
      off_d     = '0;
      wcnt_d    = '0;
      done_o    = 1'b0;
      timeout_o = 1'b0;
    end
  end

  // Offsets are published combinationally so the FSM can act
  // on the cycle the window closes.
  always_comb begin
    max_offset_o = '0;
    for (int i = 0; i < LANE_COUNT; i++)
      if (off_d[i] > max_offset_o) max_offset_o = off_d[i];
  end

  assign offsets_o = off_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q <= 1'b0;
      wcnt_q   <= '0;
      seen_q   <= '0;
      off_q    <= '0;
    end else begin
      active_q <= active_d;
      wcnt_q   <= wcnt_d;
      seen_q   <= seen_d;
      off_q    <= off_d;
    end
  end

endmodule

// File: rtl/pcie_rx_lane_deskew_ctrl.sv
// Link-level RX deskew sequencer: acquire lane skew, program
// delays, reseed the descrambler and supervise lock.
module pcie_rx_lane_deskew_ctrl
  import pcie_phy_rx_pkg::*;
#(
  parameter int LANE_COUNT    = 4,
  parameter int MAX_SKEW      = 7,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_THRESH    = 3,
  parameter int MAX_RETRIES   = 2
) (
  input logic                       clk,
  input logic                       reset,
  pcie_rx_lane_deskew_ctrl_if.slave rx
);
  localparam int OFF_W = off_w(MAX_SKEW);
  localparam int RW    = $clog2(MAX_RETRIES + 1);
  localparam int MW    = $clog2(ERR_THRESH + 1);
  localparam int SW    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [MW-1:0] MIS_MAX   = MW'(ERR_THRESH);
  localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE_CYCLES - 1);

  typedef logic [LANE_COUNT-1:0][OFF_W-1:0] offs_t;

  rx_deskew_state_e state_q, state_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [MW-1:0]    mis_q, mis_d;
  logic [SW-1:0]    scnt_q, scnt_d;
  offs_t            ref_q, ref_d;
  offs_t            dsel_q, dsel_d;
  logic             sync_q, sync_d;
  logic             ready_q, ready_d;
  logic             lost_q, lost_d;
  logic             aerr_q, aerr_d;

  logic [LANE_COUNT-1:0] mk;
  logic                  m_start, m_clear;
  logic                  m_done, m_timeout;
  offs_t                 m_offs, apply_sel;
  logic [OFF_W-1:0]      m_max;
  logic                  take;

  assign mk = rx.lane_valid & rx.lane_marker;

  pcie_rx_skew_measure #(
    .LANE_COUNT (LANE_COUNT),
    .MAX_SKEW   (MAX_SKEW)
  ) u_meas (
    .clk          (clk),
    .reset        (reset),
    .start_i      (m_start),
    .clear_i      (m_clear),
    .mk_i         (mk),
    .done_o       (m_done),
    .timeout_o    (m_timeout),
    .offsets_o    (m_offs),
    .max_offset_o (m_max)
  );

  always_comb begin
    for (int i = 0; i < LANE_COUNT; i++)
      apply_sel[i] = m_max - m_offs[i];
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    mis_d   = mis_q;
    scnt_d  = scnt_q;
    ref_d   = ref_q;
    dsel_d  = dsel_q;
    sync_d  = 1'b0;
    ready_d = ready_q;
    lost_d  = 1'b0;
    aerr_d  = aerr_q;
    m_start = 1'b0;
    m_clear = 1'b0;
    take    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        m_clear = 1'b1;
        if (rx.enable) state_d = ST_WAIT_MARKER;
      end
      ST_WAIT_MARKER: begin
        m_start = 1'b1;
        if (m_done) take = 1'b1;
        else if (|mk) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        m_start = 1'b1;
        if (m_done) begin
          take = 1'b1;
        end else if (m_timeout) begin
          retry_d = retry_q + 1'b1;
          if (retry_d == RETRY_MAX) begin
            state_d = ST_ERROR;
            aerr_d  = 1'b1;
          end else begin
            state_d = ST_WAIT_MARKER;
          end
        end
      end
      ST_APPLY: begin
        retry_d = '0;
        scnt_d  = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (scnt_q == SET_LAST) begin
          state_d = ST_LOCKED;
          ready_d = 1'b1;
          mis_d   = '0;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        m_start = 1'b1;
        if (m_done && (m_offs == ref_q)) begin
          mis_d = '0;
        end else if (m_done || m_timeout) begin
          mis_d = mis_q + 1'b1;
          if (mis_d == MIS_MAX) begin
            mis_d   = '0;
            ready_d = 1'b0;
            lost_d  = 1'b1;
            state_d = ST_WAIT_MARKER;
          end
        end
      end
      ST_ERROR: begin
        m_clear = 1'b1;
        aerr_d  = 1'b1;
        ready_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    // Delays become visible together with the reseed pulse.
    if (take) begin
      state_d = ST_APPLY;
      sync_d  = 1'b1;
      ref_d   = m_offs;
      dsel_d  = apply_sel;
    end
    if (!rx.enable) begin
      state_d = ST_IDLE;
      retry_d = '0;
      mis_d   = '0;
      scnt_d  = '0;
      ref_d   = '0;
      dsel_d  = '0;
      sync_d  = 1'b0;
      ready_d = 1'b0;
      lost_d  = 1'b0;
      aerr_d  = 1'b0;
      m_clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      retry_q <= '0;
      mis_q   <= '0;
      scnt_q  <= '0;
      ref_q   <= '0;
      dsel_q  <= '0;
      sync_q  <= 1'b0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      mis_q   <= mis_d;
      scnt_q  <= scnt_d;
      ref_q   <= ref_d;
      dsel_q  <= dsel_d;
      sync_q  <= sync_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
      aerr_q  <= aerr_d;
    end
  end

  assign rx.lane_delay_sel = dsel_q;
  assign rx.descr_sync     = sync_q;
  assign rx.rx_ready       = ready_q;
  assign rx.lock_lost      = lost_q;
  assign rx.align_error    = aerr_q;

endmodule

// File: tb/tb_pcie_rx_lane_deskew_ctrl.sv
// Bench for pcie_rx_lane_deskew_ctrl: expected delay words are
// queued per acquisition and matched on descr_sync/lock_lost.
module tb_pcie_rx_lane_deskew_ctrl;
  import pcie_phy_rx_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [11:0] sync_sb[$];
  logic [11:0] lost_sb[$];

  int pa[4] = '{2, 0, 5, 1};
  int pb[4] = '{2, 0, 4, 1};
  int pc[4] = '{0, 3, 1, 7};
  int pt[4] = '{2, 0, 5, -1};
  int p3[4] = '{0, 0, 0, -1};

  pcie_rx_lane_deskew_ctrl_if #(
    .LANE_COUNT (4),
    .MAX_SKEW   (7)
  ) bus ();

  pcie_rx_lane_deskew_ctrl #(
    .LANE_COUNT    (4),
    .MAX_SKEW      (7),
    .SETTLE_CYCLES (4),
    .ERR_THRESH    (3),
    .MAX_RETRIES   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {bus.lane_delay_sel, bus.descr_sync, bus.rx_ready,
            bus.lock_lost, bus.align_error};
  endfunction

  function automatic logic [11:0] exp_dsel(input int r[4]);
    int mx;
    logic [11:0] v;
    mx = 0;
    v  = '0;
    foreach (r[i]) if (r[i] > mx) mx = r[i];
    foreach (r[i]) v[i*3 +: 3] = lane_offset_t'(mx - r[i]);
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mark(input logic [3:0] m, input logic [3:0] v = 4'hF);
    bus.lane_marker = m;
    bus.lane_valid  = v;
    cyc(1);
    bus.lane_marker = '0;
    bus.lane_valid  = 4'hF;
  endtask

  // Lane i marks at relative cycle r[i]; -1 means never.
  task automatic window(input int r[4]);
    int n;
    bit to;
    n  = 0;
    to = 1'b0;
    foreach (r[i]) begin
      if (r[i] < 0) to = 1'b1;
      else if (r[i] + 1 > n) n = r[i] + 1;
    end
    if (to) n = 8;
    for (int t = 0; t < n; t++) begin
      logic [3:0] m;
      for (int i = 0; i < 4; i++) m[i] = (r[i] == t);
      mark(m);
    end
  endtask

  task automatic restart();
    bus.enable = 1'b0;
    cyc(1);
    bus.enable = 1'b1;
    cyc(1);
  endtask

  always @(negedge clk) begin
    if (bus.descr_sync) begin
      chk("sync_expected", 32'(sync_sb.size() > 0), 1);
      if (sync_sb.size() > 0)
        chk("dsel", bus.lane_delay_sel, sync_sb.pop_front());
    end
    if (bus.lock_lost) begin
      chk("lost_expected", 32'(lost_sb.size() > 0), 1);
      if (lost_sb.size() > 0)
        chk("lost_dsel", bus.lane_delay_sel, lost_sb.pop_front());
      chk("lost_rdy", bus.rx_ready, 0);
    end
  end

  initial begin
    reset           = 1'b0;
    bus.enable      = 1'b1;
    bus.lane_valid  = 4'hF;
    bus.lane_marker = '0;

    // reset with noisy markers
    for (int k = 0; k < 3; k++) begin
      bus.lane_marker = 4'($urandom);
      cyc(1);
      chk("rst_out", outs(), 0);
    end
    reset      = 1'b1;
    bus.enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.lane_marker = 4'($urandom);
      cyc(1);
      chk("idle_out", outs(), 0);
    end
    bus.lane_marker = '0;

    // skewed acquisition
    bus.enable = 1'b1;
    cyc(1);
    sync_sb.push_back(12'h82B);
    window(pa);
    chk("t2_sync", bus.descr_sync, 1);
    chk("t2_rdy_apply", bus.rx_ready, 0);
    cyc(1);
    chk("t2_sync_1cyc", bus.descr_sync, 0);
    cyc(3);
    chk("t2_rdy_early", bus.rx_ready, 0);
    cyc(1);
    chk("t2_rdy", bus.rx_ready, 1);

    // locked supervision
    window(pb); cyc(2);
    window(pb); cyc(2);
    chk("t5_rdy_2mis", bus.rx_ready, 1);
    window(pa); cyc(2);
    window(pb); cyc(2);
    window(pb); cyc(2);
    chk("t5_rdy_cnt_reset", bus.rx_ready, 1);
    chk("t5_no_lost", bus.lock_lost, 0);
    lost_sb.push_back(12'h82B);
    window(pt);
    chk("t5_lost", bus.lock_lost, 1);
    chk("t5_rdy_drop", bus.rx_ready, 0);
    cyc(1);
    chk("t5_lost_1cyc", bus.lock_lost, 0);
    chk("t5_dsel_held", bus.lane_delay_sel, 12'h82B);
    sync_sb.push_back(12'h1A7);
    window(pc);
    chk("t5_resync", bus.descr_sync, 1);
    cyc(5);
    chk("t5_relock", bus.rx_ready, 1);

    // reset while locked
    reset = 1'b0;
    cyc(1);
    chk("t6_rst_lock", outs(), 0);
    reset = 1'b1;
    cyc(1);
    chk("t6_rst_after", outs(), 0);

    // all lanes in one cycle
    restart();
    sync_sb.push_back(12'h000);
    mark(4'hF);
    chk("t3_same_apply", bus.descr_sync, 1);

    // repeat marker and unqualified marker ignored
    restart();
    sync_sb.push_back(12'h09C);
    mark(4'b0001);
    mark(4'b0010);
    mark(4'b0100);
    mark(4'b1001, 4'b0111);
    chk("t3_no_early", bus.descr_sync, 0);
    mark(4'b1000);
    chk("t3_rep_sync", bus.descr_sync, 1);

    // timeouts and sticky error
    restart();
    window(p3);
    chk("t4_retry1", bus.align_error, 0);
    mark(4'b0111);
    repeat (6) mark(4'b0000);
    chk("t4_aerr_pre", bus.align_error, 0);
    mark(4'b0000);
    chk("t4_aerr", bus.align_error, 1);
    chk("t4_rdy", bus.rx_ready, 0);
    window(pa);
    cyc(2);
    chk("t4_sticky", bus.align_error, 1);
    bus.enable = 1'b0;
    cyc(1);
    chk("t4_clr", outs(), 0);
    bus.enable = 1'b1;
    cyc(1);
    sync_sb.push_back(12'h82B);
    window(pa);
    chk("t4_reacq", bus.descr_sync, 1);

    // enable drop mid-window
    restart();
    mark(4'b0001);
    mark(4'b0000);
    bus.enable = 1'b0;
    mark(4'b1110);
    chk("t6_en_out", outs(), 0);
    cyc(1);
    chk("t6_en_out2", outs(), 0);

    // random skews
    for (int k = 0; k < 3; k++) begin
      int r[4];
      int mn;
      mn = 7;
      foreach (r[i]) begin
        r[i] = int'($urandom_range(0, 7));
        if (r[i] < mn) mn = r[i];
      end
      foreach (r[i]) r[i] = r[i] - mn;
      restart();
      sync_sb.push_back(exp_dsel(r));
      window(r);
      chk("rnd_sync", bus.descr_sync, 1);
      cyc(1);
      chk("rnd_sync_1cyc", bus.descr_sync, 0);
    end

    cyc(2);
    chk("sb_sync_empty", sync_sb.size(), 0);
    chk("sb_lost_empty", lost_sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
